ex_pipeline: RTL and testbench

Execute stage that consumes the ID/EX register outputs (*_E signals) and produces the EX/MEM pipeline register (*_M signals). It resolves branches and jumps, and returns pc_src and dest_pc to the fetch stage. It contains a fixed-latency iterative divider and raises ex_stall while the divider is busy; upstream uses ex_stall to hold the IF, ID and ID/EX stages. This block is the downstream end of the decode-to-execute interface.

---
 rtl/ex_pipeline.sv | 223 ++++++++++++++++++++++
 tb/tb_ex_pipeline.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_pipeline.sv
// Execute stage: ALU, multiplier, branch/jump resolution and a fixed-latency
// iterative divider feeding the EX/MEM pipeline register.
module ex_pipeline #(
  parameter int PC_W       = 16,
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_we_E,
  input  logic            mem_we_E,
  input  logic            mem_re_E,
  input  logic            branch_E,
  input  logic            mem_to_reg_E,
  input  logic            alu_src_E,
  input  logic [6:0]      ALU_control_E,
  input  logic [2:0]      mem_read_type_E,
  input  logic [1:0]      mem_store_type_E,
  input  logic [4:0]      rd_E,
  input  logic [XLEN-1:0] read_reg1_E,
  input  logic [XLEN-1:0] read_reg2_E,
  input  logic [XLEN-1:0] imm32_final_E,
  input  logic [PC_W-1:0] pc_E,
  input  logic [PC_W-1:0] pc_plus4_E,
  input  logic [PC_W-1:0] dest_pc_E,
  output logic            reg_we_M,
  output logic            mem_we_M,
  output logic            mem_re_M,
  output logic            mem_to_reg_M,
  output logic [2:0]      mem_read_type_M,
  output logic [1:0]      mem_store_type_M,
  output logic [4:0]      rd_M,
  output logic [XLEN-1:0] alu_result_M,
  output logic [XLEN-1:0] write_data_M,
  output logic [PC_W-1:0] pc_plus4_M,
  output logic            pc_src,
  output logic [PC_W-1:0] dest_pc,
  output logic            ex_stall
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam int SH_W  = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t state, state_nxt;
  logic [CNT_W-1:0] iter;
  logic stall_raw;

  logic [1:0] op_class;
  logic       m_ext, f7, cond, jump, is_div, sign_a, sign_b, div_signed;
  logic [2:0] f3;
  logic signed [XLEN-1:0] opa, opb, cmp_b;
  logic signed [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0] alu_result, pc_ext, pc4_ext;
  logic [PC_W-1:0] jalr_tgt;

  assign op_class   = ALU_control_E[6:5];
  assign m_ext      = ALU_control_E[4];
  assign f7         = ALU_control_E[3];
  assign f3         = ALU_control_E[2:0];
  assign opa        = read_reg1_E;
  assign opb        = alu_src_E ? imm32_final_E : read_reg2_E;
  assign cmp_b      = read_reg2_E;
  assign pc_ext     = {{(XLEN-PC_W){1'b0}}, pc_E};
  assign pc4_ext    = {{(XLEN-PC_W){1'b0}}, pc_plus4_E};
  assign is_div     = (op_class == 2'b00) && m_ext && f3[2];
  assign div_signed = !f3[0];

  // One shared 2*XLEN multiplier; operand extension picks mul/mulh/mulhsu/mulhu.
  assign sign_a  = (f3[1:0] != 2'b11);
  assign sign_b  = (f3[1:0] == 2'b01);
  assign mul_a   = {{XLEN{opa[XLEN-1] & sign_a}}, opa};
  assign mul_b   = {{XLEN{opb[XLEN-1] & sign_b}}, opb};
  assign product = mul_a * mul_b;

  assign jalr_tgt = (opa[PC_W-1:0] + imm32_final_E[PC_W-1:0]) & ~PC_W'(1);

  always_comb begin
    alu_result = '0;
    cond       = 1'b0;
    jump       = 1'b0;
    case (op_class)
      2'b00: begin
        if (!m_ext) begin
          case (f3)
            3'b000: alu_result = f7 ? opa - opb : opa + opb;
            3'b001: alu_result = opa << opb[SH_W-1:0];
            3'b010: alu_result = {{(XLEN-1){1'b0}}, (opa < opb)};
            3'b011: alu_result = {{(XLEN-1){1'b0}}, ($unsigned(opa) < $unsigned(opb))};
            3'b100: alu_result = opa ^ opb;
            3'b101: begin
              if (f7) alu_result = opa >>> opb[SH_W-1:0];
              else    alu_result = $unsigned(opa) >> opb[SH_W-1:0];
            end
            3'b110: alu_result = opa | opb;
            default: alu_result = opa & opb;
          endcase
        end else if (!f3[2]) begin
          alu_result = (f3[1:0] == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
      end
      2'b01: begin
        case (f3)
          3'b000: cond = (opa == cmp_b);
          3'b001: cond = (opa != cmp_b);
          3'b100: cond = (opa < cmp_b);
          3'b101: cond = (opa >= cmp_b);
          3'b110: cond = ($unsigned(opa) < $unsigned(cmp_b));
          3'b111: cond = ($unsigned(opa) >= $unsigned(cmp_b));
          default: cond = 1'b0;
        endcase
      end
      2'b10: begin
        if (f3 == 3'b000)      alu_result = imm32_final_E;
        else if (f3 == 3'b001) alu_result = pc_ext + imm32_final_E;
      end
      default: begin
        jump       = 1'b1;
        alu_result = pc4_ext;
      end
    endcase
  end

  assign pc_src  = (jump | (branch_E & cond)) & !ex_stall & !reset;
  assign dest_pc = !pc_src ? '0 : ((jump && f3 == 3'b001) ? jalr_tgt : dest_pc_E);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_nxt;
      iter  <= (state == BUSY) ? iter + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_raw = 1'b0;
    case (state)
      IDLE: begin
        if (is_div) begin
          stall_raw = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stall_raw = 1'b1;
        if (iter == CNT_W'(DIV_CYCLES - 1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_stall = stall_raw & !reset;

  // Divider stage: operand magnitudes captured at entry, one restoring step per BUSY cycle.
  logic [XLEN-1:0] quo_p1, rem_p1, dvs_p1, dvd_p1, dvd_mag, dvs_mag, div_diff, div_result;
  logic [XLEN:0]   div_shl;
  logic            q_neg_p1, r_neg_p1, rem_op_p1, zero_p1, ovf_p1, div_ge;

  assign dvd_mag  = (div_signed && opa[XLEN-1]) ? -opa : opa;
  assign dvs_mag  = (div_signed && opb[XLEN-1]) ? -opb : opb;
  assign div_shl  = {rem_p1, quo_p1[XLEN-1]};
  assign div_ge   = div_shl >= {1'b0, dvs_p1};
  assign div_diff = div_shl[XLEN-1:0] - dvs_p1;

  always_ff @(posedge clk) begin
    if (state == IDLE && is_div) begin
      quo_p1    <= dvd_mag;
      rem_p1    <= '0;
      dvs_p1    <= dvs_mag;
      dvd_p1    <= opa;
      q_neg_p1  <= div_signed && (opa[XLEN-1] ^ opb[XLEN-1]);
      r_neg_p1  <= div_signed && opa[XLEN-1];
      rem_op_p1 <= f3[1];
      zero_p1   <= (opb == '0);
      ovf_p1    <= div_signed && (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    end else if (state == BUSY) begin
      quo_p1 <= {quo_p1[XLEN-2:0], div_ge};
      rem_p1 <= div_ge ? div_diff : div_shl[XLEN-1:0];
    end
  end

  function automatic logic [XLEN-1:0] div_fixup(
    input logic [XLEN-1:0] q, input logic [XLEN-1:0] r, input logic [XLEN-1:0] dvd,
    input logic rem_op, input logic q_neg, input logic r_neg, input logic zero, input logic ovf);
    if (zero)        return rem_op ? dvd : '1;
    else if (ovf)    return rem_op ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else if (rem_op) return r_neg ? -r : r;
    else             return q_neg ? -q : q;
  endfunction

  assign div_result = div_fixup(quo_p1, rem_p1, dvd_p1, rem_op_p1, q_neg_p1, r_neg_p1,
                                zero_p1, ovf_p1);

  // EX/MEM register: bubbles the controls while the divider holds upstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_we_M         <= 1'b0;
      mem_we_M         <= 1'b0;
      mem_re_M         <= 1'b0;
      mem_to_reg_M     <= 1'b0;
      mem_read_type_M  <= '0;
      mem_store_type_M <= '0;
      rd_M             <= '0;
      alu_result_M     <= '0;
      write_data_M     <= '0;
      pc_plus4_M       <= '0;
    end else begin
      reg_we_M         <= reg_we_E && (rd_E != 5'd0) && !ex_stall;
      mem_we_M         <= mem_we_E && !ex_stall;
      mem_re_M         <= mem_re_E && !ex_stall;
      mem_to_reg_M     <= mem_to_reg_E && !ex_stall;
      mem_read_type_M  <= mem_read_type_E;
      mem_store_type_M <= mem_store_type_E;
      rd_M             <= rd_E;
      alu_result_M     <= (state == DONE) ? div_result : alu_result;
      write_data_M     <= read_reg2_E;
      pc_plus4_M       <= pc_plus4_E;
    end
  end
endmodule

// File: tb/tb_ex_pipeline.sv
// Bench for ex_pipeline: a behavioural model checked every cycle plus directed
// vectors with literal expected values.
module tb_ex_pipeline;
  localparam int PC_W = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reg_we_E, mem_we_E, mem_re_E, branch_E, mem_to_reg_E, alu_src_E;
  logic [6:0]  ALU_control_E;
  logic [2:0]  mem_read_type_E;
  logic [1:0]  mem_store_type_E;
  logic [4:0]  rd_E;
  logic [31:0] read_reg1_E, read_reg2_E, imm32_final_E;
  logic [15:0] pc_E, pc_plus4_E, dest_pc_E;
  logic        reg_we_M, mem_we_M, mem_re_M, mem_to_reg_M, pc_src, ex_stall;
  logic [2:0]  mem_read_type_M;
  logic [1:0]  mem_store_type_M;
  logic [4:0]  rd_M;
  logic [31:0] alu_result_M, write_data_M;
  logic [15:0] pc_plus4_M, dest_pc;

  ex_pipeline #(.PC_W(PC_W), .XLEN(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .reg_we_E(reg_we_E), .mem_we_E(mem_we_E), .mem_re_E(mem_re_E), .branch_E(branch_E),
    .mem_to_reg_E(mem_to_reg_E), .alu_src_E(alu_src_E), .ALU_control_E(ALU_control_E),
    .mem_read_type_E(mem_read_type_E), .mem_store_type_E(mem_store_type_E), .rd_E(rd_E),
    .read_reg1_E(read_reg1_E), .read_reg2_E(read_reg2_E), .imm32_final_E(imm32_final_E),
    .pc_E(pc_E), .pc_plus4_E(pc_plus4_E), .dest_pc_E(dest_pc_E),
    .reg_we_M(reg_we_M), .mem_we_M(mem_we_M), .mem_re_M(mem_re_M), .mem_to_reg_M(mem_to_reg_M),
    .mem_read_type_M(mem_read_type_M), .mem_store_type_M(mem_store_type_M), .rd_M(rd_M),
    .alu_result_M(alu_result_M), .write_data_M(write_data_M), .pc_plus4_M(pc_plus4_M),
    .pc_src(pc_src), .dest_pc(dest_pc), .ex_stall(ex_stall)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_div(input logic [6:0] c);
    return (c[6:5] == 2'b00) && c[4] && c[2];
  endfunction

  function automatic logic [31:0] golden(input logic [6:0] c, input logic [31:0] a,
      input logic [31:0] rs2, input logic [31:0] imm, input logic [15:0] pc,
      input logic [15:0] pc4, input logic src);
    logic [31:0] b;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    b = src ? imm : rs2;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    case (c[6:5])
      2'b00: begin
        if (!c[4]) begin
          case (c[2:0])
            3'd0: return c[3] ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'b0, sa < sb};
            3'd3: return {31'b0, a < b};
            3'd4: return a ^ b;
            3'd5: begin
              if (c[3]) begin p = sa >>> b[4:0]; return p[31:0]; end
              return a >> b[4:0];
            end
            3'd6: return a | b;
            default: return a & b;
          endcase
        end
        case (c[2:0])
          3'd0: begin p = ua * ub; return p[31:0]; end
          3'd1: begin p = sa * sb; return p[63:32]; end
          3'd2: begin p = sa * longint'(ub); return p[63:32]; end
          3'd3: begin p = ua * ub; return p[63:32]; end
          3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
          3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
          3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
          default: begin if (b == 0) return a; return a % b; end
        endcase
      end
      2'b01: return 32'h0;
      2'b10: begin
        if (c[2:0] == 3'd0) return imm;
        if (c[2:0] == 3'd1) return {16'h0, pc} + imm;
        return 32'h0;
      end
      default: return {16'h0, pc4};
    endcase
  endfunction

  function automatic logic taken(input logic [6:0] c, input logic br, input logic [31:0] a,
      input logic [31:0] b);
    if (c[6:5] == 2'b11) return 1'b1;
    if (c[6:5] != 2'b01 || !br) return 1'b0;
    case (c[2:0])
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) < $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] target(input logic [6:0] c, input logic [31:0] a,
      input logic [31:0] imm, input logic [15:0] dpc);
    logic [31:0] s;
    s = a + imm;
    if (c[6:5] == 2'b11 && c[2:0] == 3'd1) return {s[15:1], 1'b0};
    return dpc;
  endfunction

  // Model: a divide stalls for its entry cycle plus 32 busy cycles, then completes.
  typedef struct {
    logic reg_we, mem_we, mem_re, mem_to_reg, alu_ok;
    logic [2:0] rt;
    logic [1:0] st;
    logic [4:0] rd;
    logic [31:0] alu, wd;
    logic [15:0] pc4;
  } m_t;
  m_t exp_m;
  int mode = 0;
  int left = 0;

  function automatic logic model_stall();
    return !reset && (mode == 1 || (mode == 0 && is_div(ALU_control_E)));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_m <= '{default: 0};
      mode  <= 0;
      left  <= 0;
    end else begin
      exp_m.reg_we     <= !model_stall() && reg_we_E && (rd_E != 0);
      exp_m.mem_we     <= !model_stall() && mem_we_E;
      exp_m.mem_re     <= !model_stall() && mem_re_E;
      exp_m.mem_to_reg <= !model_stall() && mem_to_reg_E;
      exp_m.alu_ok     <= !model_stall();
      exp_m.rt         <= mem_read_type_E;
      exp_m.st         <= mem_store_type_E;
      exp_m.rd         <= rd_E;
      exp_m.wd         <= read_reg2_E;
      exp_m.pc4        <= pc_plus4_E;
      exp_m.alu        <= golden(ALU_control_E, read_reg1_E, read_reg2_E, imm32_final_E,
                                 pc_E, pc_plus4_E, alu_src_E);
      if (mode == 0 && is_div(ALU_control_E)) begin
        mode <= 1; left <= 32;
      end else if (mode == 1) begin
        left <= left - 1;
        if (left == 1) mode <= 2;
      end else if (mode == 2) begin
        mode <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ex_stall", 32'(ex_stall), 32'(model_stall()));
      check("pc_src", 32'(pc_src), 32'(!model_stall() &&
            taken(ALU_control_E, branch_E, read_reg1_E, read_reg2_E)));
      if (!model_stall() && taken(ALU_control_E, branch_E, read_reg1_E, read_reg2_E))
        check("dest_pc", 32'(dest_pc), 32'(target(ALU_control_E, read_reg1_E, imm32_final_E, dest_pc_E)));
      check("reg_we_M", 32'(reg_we_M), 32'(exp_m.reg_we));
      check("mem_we_M", 32'(mem_we_M), 32'(exp_m.mem_we));
      check("mem_re_M", 32'(mem_re_M), 32'(exp_m.mem_re));
      check("mem_to_reg_M", 32'(mem_to_reg_M), 32'(exp_m.mem_to_reg));
      check("mem_read_type_M", 32'(mem_read_type_M), 32'(exp_m.rt));
      check("mem_store_type_M", 32'(mem_store_type_M), 32'(exp_m.st));
      check("rd_M", 32'(rd_M), 32'(exp_m.rd));
      check("write_data_M", write_data_M, exp_m.wd);
      check("pc_plus4_M", 32'(pc_plus4_M), 32'(exp_m.pc4));
      if (exp_m.alu_ok) check("alu_result_M", alu_result_M, exp_m.alu);
    end
  end

  task automatic set_e(input logic [6:0] c, input logic [31:0] a, input logic [31:0] r2,
      input logic [31:0] im, input logic src, input logic br, input logic [4:0] rd,
      input logic we, input logic [15:0] pc, input logic [15:0] pc4, input logic [15:0] dpc);
    @(posedge clk); #1;
    ALU_control_E = c; read_reg1_E = a; read_reg2_E = r2; imm32_final_E = im;
    alu_src_E = src; branch_E = br; rd_E = rd; reg_we_E = we;
    pc_E = pc; pc_plus4_E = pc4; dest_pc_E = dpc;
    mem_we_E = 1'b0; mem_re_E = 1'b0; mem_to_reg_E = 1'b0;
    mem_read_type_E = 3'd0; mem_store_type_E = 2'd0;
  endtask

  task automatic nop();
    set_e(7'b0, 0, 0, 0, 1'b0, 1'b0, 5'd0, 1'b0, 16'h0, 16'h4, 16'h0);
  endtask

  task automatic rand_e();
    ALU_control_E = 7'($urandom); read_reg1_E = $urandom; read_reg2_E = $urandom;
    imm32_final_E = $urandom; alu_src_E = 1'($urandom); branch_E = 1'($urandom);
    rd_E = 5'($urandom); reg_we_E = 1'($urandom); mem_we_E = 1'($urandom);
    mem_re_E = 1'($urandom); mem_to_reg_E = 1'($urandom);
    mem_read_type_E = 3'($urandom); mem_store_type_E = 2'($urandom);
    pc_E = 16'($urandom); pc_plus4_E = 16'($urandom); dest_pc_E = 16'($urandom);
  endtask

  task automatic op_lit(input string nm, input logic [6:0] c, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp);
    set_e(c, a, b, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1, 16'h100, 16'h104, 16'h0);
    @(negedge clk);
    @(negedge clk);
    check(nm, alu_result_M, exp);
  endtask

  task automatic run_div(input string nm, input logic [6:0] c, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] exp);
    int n;
    n = 0;
    set_e(c, a, b, 32'h0, 1'b0, 1'b0, 5'd7, 1'b1, 16'h10, 16'h14, 16'h0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ex_stall) n++;
      else break;
    end
    check({nm, " stall cycles"}, n, 33);
    nop();
    @(negedge clk);
    check(nm, alu_result_M, exp);
    check({nm, " reg_we_M"}, 32'(reg_we_M), 32'd1);
    check({nm, " rd_M"}, 32'(rd_M), 32'd7);
  endtask

  logic [6:0] ops [0:23] = '{
    7'b0000000, 7'b0001000, 7'b0000001, 7'b0000010, 7'b0000011, 7'b0000100,
    7'b0000101, 7'b0001101, 7'b0000110, 7'b0000111, 7'b0010000, 7'b0010001,
    7'b0010010, 7'b0010011, 7'b0100000, 7'b0100001, 7'b0100100, 7'b0100101,
    7'b0100110, 7'b0100111, 7'b1000000, 7'b1000001, 7'b1100000, 7'b1100001};

  initial begin
    int bad;
    logic [31:0] a;
    logic [15:0] pc;
    rand_e();
    repeat (2) begin
      @(posedge clk); #1;
      rand_e();
    end
    @(negedge clk);
    check("reset reg_we_M", 32'(reg_we_M), 0);
    check("reset mem_we_M", 32'(mem_we_M), 0);
    check("reset mem_re_M", 32'(mem_re_M), 0);
    check("reset alu_result_M", alu_result_M, 0);
    check("reset rd_M", 32'(rd_M), 0);
    check("reset ex_stall", 32'(ex_stall), 0);
    check("reset pc_src", 32'(pc_src), 0);
    nop();
    reset = 1'b0;

    set_e(7'b0000000, 32'h7FFFFFFF, 32'h0, 32'h1, 1'b1, 1'b0, 5'd5, 1'b1, 16'h0, 16'h4, 16'h0);
    @(negedge clk); @(negedge clk);
    check("add overflow wrap", alu_result_M, 32'h80000000);
    check("add reg_we_M", 32'(reg_we_M), 1);
    set_e(7'b0000000, 32'h7FFFFFFF, 32'h0, 32'h1, 1'b1, 1'b0, 5'd0, 1'b1, 16'h0, 16'h4, 16'h0);
    @(negedge clk); @(negedge clk);
    check("rd0 reg_we_M", 32'(reg_we_M), 0);

    set_e(7'b0100000, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 16'h30, 16'h34, 16'h0040);
    @(negedge clk);
    check("beq pc_src", 32'(pc_src), 1);
    check("beq dest_pc", 32'(dest_pc), 32'h0040);
    set_e(7'b0100001, 32'd5, 32'd5, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 16'h30, 16'h34, 16'h0040);
    @(negedge clk);
    check("bne pc_src", 32'(pc_src), 0);

    set_e(7'b1100001, 32'h103, 32'h0, 32'h4, 1'b1, 1'b0, 5'd1, 1'b1, 16'h1C, 16'h0020, 16'h0);
    @(negedge clk);
    check("jalr dest_pc", 32'(dest_pc), 32'h0106);
    @(negedge clk);
    check("jalr link", alu_result_M, 32'h00000020);

    op_lit("sub", 7'b0001000, 32'd5, 32'd7, 32'hFFFFFFFE);
    op_lit("sra", 7'b0001101, 32'h80000000, 32'd4, 32'hF8000000);
    op_lit("mulhu", 7'b0010011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    op_lit("mulhsu", 7'b0010010, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF);

    run_div("div -7/2", 7'b0010100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_div("rem -7%2", 7'b0010110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
    run_div("divu by zero", 7'b0010101, 32'h1234, 32'd0, 32'hFFFFFFFF);
    run_div("remu by zero", 7'b0010111, 32'h1234, 32'd0, 32'h00001234);
    run_div("div overflow", 7'b0010100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_div("divu 100/7", 7'b0010101, 32'd100, 32'd7, 32'd14);
    run_div("rem 100%-7", 7'b0010110, 32'd100, 32'hFFFFFFF9, 32'd2);

    set_e(7'b0010100, 32'd100, 32'd3, 32'h0, 1'b0, 1'b0, 5'd9, 1'b1, 16'h0, 16'h4, 16'h0);
    repeat (11) @(negedge clk);
    nop();
    reset = 1'b1;
    nop();
    reset = 1'b0;
    @(negedge clk);
    check("abort ex_stall", 32'(ex_stall), 0);
    check("abort reg_we_M", 32'(reg_we_M), 0);
    check("abort alu_result_M", alu_result_M, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (reg_we_M || ex_stall || alu_result_M == 32'd33) bad++;
    end
    check("abort no late write", bad, 0);

    for (int i = 0; i < 24; i++) begin
      for (int j = 0; j < 3; j++) begin
        a  = $urandom;
        pc = 16'($urandom);
        set_e(ops[i], a, (j == 0) ? a : $urandom, $urandom, 1'($urandom), 1'($urandom),
              5'($urandom), 1'($urandom), pc, pc + 16'd4, 16'($urandom));
        mem_we_E = 1'($urandom); mem_re_E = 1'($urandom); mem_to_reg_E = 1'($urandom);
        mem_read_type_E = 3'($urandom); mem_store_type_E = 2'($urandom);
      end
    end

    repeat (3) nop();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
